psum_acc_row: RTL and testbench

Accumulates `col`-wide partial-sum row vectors from the MAC-array output FIFO over several input-channel passes into an internal row buffer. When the last pass completes, it drains each finished row into the normalization stage (`sfp_row`). For each row it drives `sfp_in` and sequences the `acc` and `div` strobes that stage requires. It sits directly upstream of `sfp_row`, between the output FIFO and the SFP.

---
 rtl/psum_pkg.sv | 17 +
 rtl/psum_sat_add.sv | 30 +++
 rtl/psum_acc_row.sv | 167 ++++++++++++++++
 tb/tb_psum_acc_row.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum row accumulator: FSM state encoding
// and the signed range of a default-width partial-sum lane.
package psum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCUM     = 3'd1,
        ST_DRAIN_ACC = 3'd2,
        ST_DRAIN_DIV = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int PSUM_W   = 20;
    localparam int PSUM_MAX = (32'sd1 <<< (PSUM_W - 1)) - 32'sd1;
    localparam int PSUM_MIN = -(32'sd1 <<< (PSUM_W - 1));

endpackage

// File: rtl/psum_sat_add.sv
// One signed partial-sum lane adder. Defining PSUM_ACC_SAT_EN clamps the result
// to the signed lane range; otherwise the sum wraps modulo 2^W.
module psum_sat_add #(
    parameter int W = 20
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

`ifdef PSUM_ACC_SAT_EN
    logic signed [W:0] wide_s;

    // One guard bit exposes overflow; clamp towards the sign of the true sum.
    always_comb begin
        wide_s = {a_i[W-1], a_i} + {b_i[W-1], b_i};
        if (wide_s[W] != wide_s[W-1]) begin
            sum_o = wide_s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_o = wide_s[W-1:0];
        end
    end
`else
    // Plain two's-complement add, wrapping on overflow.
    always_comb begin
        sum_o = a_i + b_i;
    end
`endif

endmodule

// File: rtl/psum_acc_row.sv
// Accumulates partial-sum rows over K passes into a row buffer, then drains each
// row to the SFP with an acc/div strobe pair. Lane saturation via PSUM_ACC_SAT_EN.
module psum_acc_row
    import psum_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int depth   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               cfg_passes,
    input  logic [$clog2(depth):0]   cfg_rows,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*bw_psum-1:0]   in_data,
    input  logic                     sfp_stall,
    output logic [col*bw_psum-1:0]   sfp_in,
    output logic                     sfp_acc,
    output logic                     sfp_div,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = $clog2(depth);
    localparam int DW = col*bw_psum;
    localparam logic [RW:0] DEPTH_L = (RW+1)'(depth);

    state_e          state_q, state_d;
    logic [RW-1:0]   r_q, r_d;
    logic [3:0]      p_q, p_d;
    logic [RW:0]     rows_q, rows_d;
    logic [3:0]      passes_q, passes_d;
    logic            in_ready_q, busy_q, done_q, sfp_acc_q, sfp_div_q;
    logic [DW-1:0]   sfp_in_q;
    logic [DW-1:0]   buf_q [depth];

    logic [DW-1:0]   rd_row_s, sum_row_s, wr_row_s;
    logic [RW:0]     rows_eff_s;
    logic [3:0]      passes_eff_s;
    logic            accept_s, last_row_s, last_pass_s, wr_en_s, issue_acc_s;

    assign rows_eff_s   = (cfg_rows == '0) ? (RW+1)'(1) :
                          (cfg_rows > DEPTH_L) ? DEPTH_L : cfg_rows;
    assign passes_eff_s = (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
    assign accept_s     = in_valid && in_ready_q;
    assign last_row_s   = ({1'b0, r_q} == (rows_q - (RW+1)'(1)));
    assign last_pass_s  = (p_q == (passes_q - 4'd1));
    assign issue_acc_s  = (state_q == ST_DRAIN_ACC) && !sfp_stall;
    assign rd_row_s     = buf_q[r_q];
    // The first pass overwrites whatever a previous or aborted job left behind.
    assign wr_row_s     = (p_q == 4'd0) ? in_data : sum_row_s;

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_sat_add #(.W(bw_psum)) u_add (
            .a_i   (rd_row_s[i*bw_psum +: bw_psum]),
            .b_i   (in_data[i*bw_psum +: bw_psum]),
            .sum_o (sum_row_s[i*bw_psum +: bw_psum])
        );
    end

    // Next-state logic for the job sequencer and its row/pass counters.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        p_d      = p_q;
        rows_d   = rows_q;
        passes_d = passes_q;
        wr_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                r_d = '0;
                p_d = 4'd0;
                if (start) begin
                    state_d  = ST_ACCUM;
                    rows_d   = rows_eff_s;
                    passes_d = passes_eff_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    if (last_row_s) begin
                        r_d     = '0;
                        p_d     = p_q + 4'd1;
                        state_d = last_pass_s ? ST_DRAIN_ACC : ST_ACCUM;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_DRAIN_ACC: begin
                if (sfp_stall) begin
                    state_d = ST_DRAIN_ACC;
                end else begin
                    state_d = ST_DRAIN_DIV;
                end
            end
            ST_DRAIN_DIV: begin
                if (last_row_s) begin
                    state_d = ST_DONE;
                end else begin
                    r_d     = r_q + RW'(1);
                    state_d = ST_DRAIN_ACC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; strobes appear the cycle after the issuing state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            p_q        <= 4'd0;
            rows_q     <= (RW+1)'(1);
            passes_q   <= 4'd1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sfp_acc_q  <= 1'b0;
            sfp_div_q  <= 1'b0;
            sfp_in_q   <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            p_q        <= p_d;
            rows_q     <= rows_d;
            passes_q   <= passes_d;
            in_ready_q <= (state_d == ST_ACCUM);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_q == ST_DONE);
            sfp_acc_q  <= issue_acc_s;
            sfp_div_q  <= (state_q == ST_DRAIN_DIV);
            if (issue_acc_s) begin
                sfp_in_q <= rd_row_s;
            end
        end
    end

    // Row buffer storage; intentionally not reset since pass 0 always overwrites.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_q[r_q] <= wr_row_s;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sfp_acc  = sfp_acc_q;
    assign sfp_div  = sfp_div_q;
    assign sfp_in   = sfp_in_q;

endmodule

// File: tb/tb_psum_acc_row.sv
// Self-checking bench for psum_acc_row: directed jobs from the test plan plus
// random jobs, checked against a lane-arithmetic reference model and cycle timeline.
module tb_psum_acc_row;
    import psum_pkg::*;

    localparam int COL = 8;
    localparam int BWP = 20;
    localparam int DW  = COL*BWP;

    logic            clk = 1'b0;
    logic            reset, start, in_valid, sfp_stall;
    logic [3:0]      cfg_passes;
    logic [4:0]      cfg_rows;
    logic [DW-1:0]   in_data, sfp_in;
    logic            in_ready, sfp_acc, sfp_div, busy, done;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] din [15][16];
    logic [DW-1:0] got_row [16];

    psum_acc_row dut (
        .clk(clk), .reset(reset), .start(start), .cfg_passes(cfg_passes),
        .cfg_rows(cfg_rows), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sfp_stall(sfp_stall), .sfp_in(sfp_in),
        .sfp_acc(sfp_acc), .sfp_div(sfp_div), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lane(input logic [DW-1:0] row, input int i);
        logic [BWP-1:0] x;
        x = row[i*BWP +: BWP];
        return int'($signed(x));
    endfunction

    function automatic int lane_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef PSUM_ACC_SAT_EN
        if (s > PSUM_MAX) s = PSUM_MAX;
        if (s < PSUM_MIN) s = PSUM_MIN;
`else
        if (s > PSUM_MAX) s = s - (PSUM_MAX - PSUM_MIN + 1);
        if (s < PSUM_MIN) s = s + (PSUM_MAX - PSUM_MIN + 1);
`endif
        return s;
    endfunction

    function automatic logic [DW-1:0] row_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] row;
        logic [31:0]   t;
        for (int i = 0; i < COL; i++) begin
            t = lane_add(lane(a, i), lane(b, i));
            row[i*BWP +: BWP] = t[BWP-1:0];
        end
        return row;
    endfunction

    function automatic logic [DW-1:0] mk_all(input int v);
        logic [DW-1:0] row;
        logic [31:0]   t;
        t = v;
        for (int i = 0; i < COL; i++) row[i*BWP +: BWP] = t[BWP-1:0];
        return row;
    endfunction

    task automatic set_lane(input int p, input int r, input int i, input int v);
        logic [31:0] t;
        t = v;
        din[p][r][i*BWP +: BWP] = t[BWP-1:0];
    endtask

    task automatic fill_random();
        logic [31:0] t;
        for (int p = 0; p < 15; p++)
            for (int r = 0; r < 16; r++)
                for (int i = 0; i < COL; i++) begin
                    t = $urandom;
                    din[p][r][i*BWP +: BWP] = t[BWP-1:0];
                end
    endtask

    task automatic run_job(input logic [3:0] cp, input logic [4:0] cr, input int stall_n,
                           input bit gaps, input bit glitch);
        int k, rows, beat;
        logic [DW-1:0] exp_row [16];
        k    = (cp == 4'd0) ? 1 : int'(cp);
        rows = (cr == 5'd0) ? 1 : (cr > 5'd16) ? 16 : int'(cr);
        for (int r = 0; r < rows; r++) begin
            exp_row[r] = din[0][r];
            for (int p = 1; p < k; p++) exp_row[r] = row_add(exp_row[r], din[p][r]);
        end
        chk("idle_in_ready", DW'(in_ready), DW'(1'b0));
        start = 1'b1; cfg_passes = cp; cfg_rows = cr;
        tick();
        start = 1'b0; cfg_passes = 4'($urandom); cfg_rows = 5'($urandom);
        beat = 0;
        for (int p = 0; p < k; p++) begin
            for (int r = 0; r < rows; r++) begin
                if (gaps && (beat == 1 || $urandom_range(0, 2) == 0)) begin
                    in_valid = 1'b0; in_data = {5{32'($urandom)}};
                    tick();
                end
                chk("accum_in_ready", DW'(in_ready), DW'(1'b1));
                chk("accum_busy", DW'(busy), DW'(1'b1));
                in_valid = 1'b1; in_data = din[p][r]; start = glitch;
                tick();
                start = 1'b0;
                beat++;
            end
        end
        in_valid = 1'b0; in_data = {5{32'($urandom)}};
        for (int i = 0; i <= stall_n; i++) begin
            chk("pre_acc_quiet", DW'({sfp_acc, sfp_div}), DW'(2'b00));
            chk("drain_busy", DW'(busy), DW'(1'b1));
            sfp_stall = (i < stall_n);
            tick();
        end
        for (int r = 0; r < rows; r++) begin
            chk("acc_strobe", DW'({sfp_acc, sfp_div}), DW'(2'b10));
            chk("acc_row", sfp_in, exp_row[r]);
            got_row[r] = sfp_in;
            sfp_stall = 1'($urandom_range(0, 1));
            tick();
            chk("div_strobe", DW'({sfp_acc, sfp_div}), DW'(2'b01));
            chk("div_row", sfp_in, exp_row[r]);
            chk("div_busy", DW'(busy), DW'(1'b1));
            sfp_stall = 1'b0;
            tick();
        end
        chk("done_pulse", DW'({done, busy, sfp_acc, sfp_div}), DW'(4'b1000));
        tick();
        chk("done_low", DW'({done, busy, in_ready}), DW'(3'b000));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; sfp_stall = 1'b0;
        cfg_passes = 4'd0; cfg_rows = 5'd0; in_data = '0;
        tick(); tick();
        chk("rst_outputs", DW'({in_ready, busy, done, sfp_acc, sfp_div}), DW'(5'b00000));
        chk("rst_sfp_in", sfp_in, '0);
        reset = 1'b1;
        tick();
        chk("post_rst_idle", DW'({in_ready, busy}), DW'(2'b00));

        // 1: basic drain, two rows
        fill_random();
        din[0][0] = mk_all(5);
        din[0][1] = mk_all(-3);
        run_job(4'd1, 5'd2, 0, 1'b0, 1'b0);
        chk("t1_row0", got_row[0], mk_all(5));
        chk("t1_row1", got_row[1], mk_all(-3));

        // 2: three-pass accumulation
        fill_random();
        set_lane(0, 0, 0, 100); set_lane(1, 0, 0, -20); set_lane(2, 0, 0, 7);
        set_lane(0, 0, 7, 1);   set_lane(1, 0, 7, 1);   set_lane(2, 0, 7, 1);
        run_job(4'd3, 5'd1, 0, 1'b0, 1'b0);
        chk("t2_lane0", DW'(lane(got_row[0], 0)), DW'(87));
        chk("t2_lane7", DW'(lane(got_row[0], 7)), DW'(3));

        // 3: lane overflow
        fill_random();
        set_lane(0, 0, 0, 524000); set_lane(1, 0, 0, 1000);
        run_job(4'd2, 5'd1, 0, 1'b0, 1'b0);
`ifdef PSUM_ACC_SAT_EN
        chk("t3_overflow", DW'(lane(got_row[0], 0)), DW'(524287));
`else
        chk("t3_overflow", DW'(lane(got_row[0], 0)), DW'(-523576));
`endif

        // 4: input gaps and three-cycle stall at drain entry
        fill_random();
        run_job(4'd2, 5'd3, 3, 1'b1, 1'b0);

        // 5: reset after two of four beats, then a clean single-beat job
        fill_random();
        start = 1'b1; cfg_passes = 4'd2; cfg_rows = 5'd2;
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b1; in_data = din[0][r];
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("t5_rst_flags", DW'({in_ready, busy, done, sfp_acc, sfp_div}), DW'(5'b00000));
        chk("t5_rst_sfp_in", sfp_in, '0);
        tick();
        reset = 1'b1;
        tick();
        din[0][0] = mk_all(9);
        run_job(4'd1, 5'd1, 0, 1'b0, 1'b0);
        chk("t5_restart_row", got_row[0], mk_all(9));

        // 6: zero config with start pulsed mid-job
        fill_random();
        run_job(4'd0, 5'd0, 0, 1'b0, 1'b1);

        // boundaries: rows clamp to depth, maximum passes
        fill_random();
        run_job(4'd1, 5'd20, 1, 1'b0, 1'b0);
        fill_random();
        run_job(4'd15, 5'd2, 0, 1'b1, 1'b1);

        for (int j = 0; j < 4; j++) begin
            fill_random();
            run_job(4'($urandom_range(0, 4)), 5'($urandom_range(0, 20)),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
